rtr_node_inject_ctrl: RTL and testbench
=======================================

// Module: rtr_node_inject_ctrl
// PURPOSE
//  Injection-side channel controller for one router node port. Accepts a flit stream from the
//  network interface, allocates an output VC per packet, and tracks per-VC credits. Drives the
//  router's channel_in_ip slice (head/tail packet format, no link ctrl). Consumes returned credits
//  from the router's flow_ctrl_out_ip slice.
// PARAMETERS
//  num_vcs          4   VCs on the channel; vc_idx_width = clogb(num_vcs)
//  buffer_size      8   flit slots per VC at router input = initial credits per VC
//  flit_data_width  64  flit payload width
//  Derived: cred_width = clogb(buffer_size+1); channel_width = 1+vc_idx_width+2+flit_data_width
// PORTS
//  clk              in   1                  clock
//  reset            in   1                  synchronous, active-high
//  in_valid         in   1                  NI flit valid
//  in_ready         out  1                  flit accepted when in_valid & in_ready
//  in_head          in   1                  flit is head
//  in_tail          in   1                  flit is tail (head&tail = single-flit packet)
//  in_data          in   flit_data_width    flit payload (head carries route info)
//  channel_out      out  channel_width      {valid, vc[vc_idx_width], head, tail, data} to router
//  flow_ctrl_in     in   1+vc_idx_width     {credit_valid, credit_vc} from router
//  vc_credits       out  num_vcs*cred_width per-VC credit count, VC0 in MSBs
//  busy             out  1                  state == SEND
//  error            out  1                  sticky protocol/credit error
// BEHAVIOUR
//  - Design: one clock clk; reset is synchronous and active-high.
//  - Reset: state=IDLE, channel_out=0, all credits=buffer_size, rr pointer=0, error=0, in_ready=0.
//  - in_ready is combinational from registered state/credits only (never from in_valid).
//  - FSM IDLE: eligible VC = credits>0 (see CONFIGURATION). in_ready = 1 if any VC is eligible.
//    It is also 1 when the current flit is not a head (drop path).
//    - Head accepted: choose the eligible VC by round-robin starting at rr pointer.
//      Set cur_vc and rr pointer = cur_vc+1 mod num_vcs. Emit the flit.
//      If in_tail, stay in IDLE; otherwise go to SEND.
//    - Non-head in IDLE: consume and drop it, set error.
//  - FSM SEND: in_ready = (credits[cur_vc] > 0). Accepted flits are emitted on cur_vc.
//    - Tail accepted: go to IDLE.
//    - Head accepted in SEND: set error. The flit is sent as a body flit; the state is unchanged.
//  - Output latency: channel_out is registered. An accepted flit appears exactly 1 cycle later
//    with valid=1. channel_out valid=0 in every cycle with no accept; other fields are don't-care.
//  - Credits: decrement credits[vc] in the accept cycle. Increment on credit_valid for credit_vc.
//    - Same VC, same cycle: count unchanged.
//    - A credit returned in cycle t is first usable for in_ready in cycle t+1.
//    - Increment at buffer_size: count saturates and error is set.
//    - credit_vc >= num_vcs: ignored and error is set.
//  - error clears only on reset.
//  - Reset mid-packet: the packet is abandoned and credits restore to buffer_size.
//    The router is reset in the same cycle by system convention.
// CONFIGURATION
//  RTR_INJ_ATOMIC_VC_EN defined: a VC is eligible for a head only if credits == buffer_size
//    (VC fully drained downstream; atomic VC allocation). Body flits still need only credits>0.
//  Undefined: a VC is eligible for a head when credits > 0.
// TESTING
//  1 Reset, then a 3-flit packet (H,B,T).
//    -> flits on VC0 at cycles +1,+2,+3 with head/tail set correctly; vc_credits[0]=5.
//  2 Four back-to-back single-flit packets, no credits returned.
//    -> VCs 0,1,2,3 in order; each of those VCs ends with credits 7.
//  3 Packet of 10 body flits on VC0, no credits returned.
//    -> 8 flits sent; in_ready=0 and busy=1 thereafter.
//    -> one credit_valid on VC0: exactly one more flit sent, the cycle after the credit.
//  4 Same-cycle send and credit return on VC2 at credits=3.
//    -> credits stay at 3; error=0.
//  5 Body flit in IDLE; separately, a credit returned on a VC at 8.
//    -> flit dropped and error=1; credit count held at 8.
//  6 With RTR_INJ_ATOMIC_VC_EN: VC0 at 7 credits, other VCs full.
//    -> the next head goes to VC1. Without the macro, the rr pointer decides (VC0 if pointer=0).

Source files
------------

// File: rtl/rtr_node_inject_ctrl.sv
// Injection-side channel controller for one router node port.
// Allocates an output VC per packet (round-robin), tracks per-VC credits and
// drives the router channel slice {valid, vc, head, tail, data} through a register.
// Optional feature: define RTR_INJ_ATOMIC_VC_EN so that a head may only take a
// VC whose credits are all home (credits == BufferSize).
module rtr_node_inject_ctrl #(
   parameter int unsigned NumVcs        = 4,
   parameter int unsigned BufferSize    = 8,
   parameter int unsigned FlitDataWidth = 64,
   localparam int unsigned VcIdxWidth   = (NumVcs > 1) ? $clog2(NumVcs) : 1,
   localparam int unsigned CredWidth    = $clog2(BufferSize + 1),
   localparam int unsigned ChannelWidth = 1 + VcIdxWidth + 2 + FlitDataWidth
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic                          in_head_i,
   input  logic                          in_tail_i,
   input  logic [FlitDataWidth-1:0]      in_data_i,
   output logic [ChannelWidth-1:0]       channel_out_o,
   input  logic [VcIdxWidth:0]           flow_ctrl_in_i,
   output logic [NumVcs*CredWidth-1:0]   vc_credits_o,
   output logic                          busy_o,
   output logic                          error_o
);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   localparam logic [CredWidth-1:0] CredFull = CredWidth'(BufferSize);

   state_e                  state_q, state_d;
   logic [CredWidth-1:0]    cred_q [NumVcs];
   logic [CredWidth-1:0]    cred_d [NumVcs];
   logic [VcIdxWidth-1:0]   rr_q, rr_d;
   logic [VcIdxWidth-1:0]   cur_vc_q, cur_vc_d;
   logic                    err_q, err_d;
   logic [ChannelWidth-1:0] chan_q, chan_d;

   logic [NumVcs-1:0]       head_elig;
   logic                    pick_found;
   logic [VcIdxWidth-1:0]   pick_vc;
   logic [VcIdxWidth-1:0]   idx_v;
   logic                    emit, emit_head;
   logic [VcIdxWidth-1:0]   emit_vc;
   logic                    ready;
   logic                    cred_err;

   logic                    fc_valid;
   logic [VcIdxWidth-1:0]   fc_vc;
   logic                    fc_in_range;

   assign fc_valid    = flow_ctrl_in_i[VcIdxWidth];
   assign fc_vc       = flow_ctrl_in_i[VcIdxWidth-1:0];
   assign fc_in_range = 32'(fc_vc) < NumVcs;

   // Which VCs may accept a new packet head.
   always_comb begin
      head_elig = '0;
      for (int v = 0; v < NumVcs; v++) begin
`ifdef RTR_INJ_ATOMIC_VC_EN
         head_elig[v] = (cred_q[v] == CredFull);
`else
         head_elig[v] = (cred_q[v] != '0);
`endif
      end
   end

   // Round-robin search for the first eligible VC starting at the pointer.
   always_comb begin
      pick_found = 1'b0;
      pick_vc    = rr_q;
      idx_v      = '0;
      for (int unsigned i = 0; i < NumVcs; i++) begin
         idx_v = VcIdxWidth'((32'(rr_q) + i) % NumVcs);
         if (!pick_found && head_elig[idx_v]) begin
            pick_found = 1'b1;
            pick_vc    = idx_v;
         end
      end
   end

   // FSM next state, handshake and flit emission.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      cur_vc_d  = cur_vc_q;
      err_d     = err_q;
      ready     = 1'b0;
      emit      = 1'b0;
      emit_vc   = cur_vc_q;
      emit_head = in_head_i;
      unique case (state_q)
         StIdle: begin
            // Non-head flits are always taken so they can be dropped.
            ready = pick_found | ~in_head_i;
         end
         StSend: begin
            ready = (cred_q[cur_vc_q] != '0);
         end
         default: ;
      endcase
      in_ready_o = ready & ~reset_i;
      if (in_valid_i && in_ready_o) begin
         unique case (state_q)
            StIdle: begin
               if (in_head_i) begin
                  emit     = 1'b1;
                  emit_vc  = pick_vc;
                  cur_vc_d = pick_vc;
                  rr_d     = VcIdxWidth'((32'(pick_vc) + 1) % NumVcs);
                  if (!in_tail_i) state_d = StSend;
               end else begin
                  err_d = 1'b1;
               end
            end
            StSend: begin
               // A stray head mid-packet is forwarded as a body flit.
               emit      = 1'b1;
               emit_head = 1'b0;
               if (in_head_i) err_d = 1'b1;
               if (in_tail_i) state_d = StIdle;
            end
            default: ;
         endcase
      end
      chan_d = '0;
      if (emit) chan_d = {1'b1, emit_vc, emit_head, in_tail_i, in_data_i};
   end

   // Per-VC credit update; simultaneous send and return on one VC cancel out.
   always_comb begin
      cred_err = fc_valid & ~fc_in_range;
      for (int v = 0; v < NumVcs; v++) begin
         logic inc, dec;
         inc       = fc_valid & fc_in_range & (fc_vc == VcIdxWidth'(v));
         dec       = emit & (emit_vc == VcIdxWidth'(v));
         cred_d[v] = cred_q[v];
         if (inc && !dec) begin
            if (cred_q[v] == CredFull) cred_err = 1'b1;
            else                       cred_d[v] = cred_q[v] + 1'b1;
         end else if (dec && !inc) begin
            cred_d[v] = cred_q[v] - 1'b1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         rr_q     <= '0;
         cur_vc_q <= '0;
         err_q    <= 1'b0;
         chan_q   <= '0;
         for (int v = 0; v < NumVcs; v++) cred_q[v] <= CredFull;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         cur_vc_q <= cur_vc_d;
         err_q    <= err_d | cred_err;
         chan_q   <= chan_d;
         for (int v = 0; v < NumVcs; v++) cred_q[v] <= cred_d[v];
      end
   end

   // Flatten credit counters, VC0 in the MSBs.
   always_comb begin
      vc_credits_o = '0;
      for (int v = 0; v < NumVcs; v++) begin
         vc_credits_o[(NumVcs-1-v)*CredWidth +: CredWidth] = cred_q[v];
      end
   end

   assign channel_out_o = chan_q;
   assign busy_o        = (state_q == StSend);
   assign error_o       = err_q;

endmodule

// File: tb/tb_rtr_node_inject_ctrl.sv
// Self-checking bench for rtr_node_inject_ctrl (4 VCs, 8 credits, 64-bit data).
// Emitted flits are checked by a scoreboard; state is checked from a vector table
// and a few hand-written multi-cycle sequences.
module tb_rtr_node_inject_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_head, in_tail;
   logic [63:0] in_data;
   logic [68:0] channel_out;
   logic [2:0]  flow_ctrl_in;
   logic [15:0] vc_credits;
   logic        busy, error;

   always #5 clk = ~clk;

   rtr_node_inject_ctrl #(
      .NumVcs        (4),
      .BufferSize    (8),
      .FlitDataWidth (64)
   ) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .in_head_i      (in_head),
      .in_tail_i      (in_tail),
      .in_data_i      (in_data),
      .channel_out_o  (channel_out),
      .flow_ctrl_in_i (flow_ctrl_in),
      .vc_credits_o   (vc_credits),
      .busy_o         (busy),
      .error_o        (error)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [1:0]  vc;
      logic        head;
      logic        tail;
      logic [63:0] data;
   } flit_t;

   flit_t exp_q[$];

   typedef struct {
      logic        rst, v, h, t, cv;
      logic [1:0]  cvc;
      logic        ready, emit;
      logic [1:0]  evc;
      logic        ehead, ebusy, eerr;
      logic [15:0] ecred;
   } row_t;

   localparam int NRows = 14;
   row_t rows[NRows];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every flit pushed before an edge must appear right after it.
   always @(negedge clk) begin
      flit_t got, e;
      if (channel_out[68] || exp_q.size() != 0) begin
         got = channel_out[67:0];
         if (!channel_out[68]) begin
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL chan_missing: got valid 0 expected flit vc%0d data %0h", e.vc, e.data);
         end else if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL chan_unexpected: got flit vc%0d data %0h expected none", got.vc,
                     got.data);
         end else begin
            e = exp_q.pop_front();
            check("chan_ctrl", 64'({got.vc, got.head, got.tail}), 64'({e.vc, e.head, e.tail}));
            check("chan_data", got.data, e.data);
         end
      end
   end

   function automatic row_t mk(logic rst, v, h, t, cv, logic [1:0] cvc, logic rdy, em,
                               logic [1:0] evc, logic eh, eb, ee, logic [15:0] ec);
      row_t r;
      r.rst = rst; r.v = v; r.h = h; r.t = t; r.cv = cv; r.cvc = cvc;
      r.ready = rdy; r.emit = em; r.evc = evc; r.ehead = eh;
      r.ebusy = eb; r.eerr = ee; r.ecred = ec;
      return r;
   endfunction

   // One cycle of stimulus; in_ready is checked against the expected value.
   task automatic step(input logic v, h, t, input logic [63:0] d, input logic cv,
                       input logic [1:0] cvc, input logic exp_rdy, input logic [1:0] evc,
                       input logic ehead, input string name);
      @(negedge clk);
      in_valid = v; in_head = h; in_tail = t; in_data = d; flow_ctrl_in = {cv, cvc};
      #1;
      check({name, "_ready"}, 64'(in_ready), 64'(exp_rdy));
      if (v && exp_rdy) exp_q.push_back({evc, ehead, t, d});
   endtask

   task automatic idle(input logic cv, input logic [1:0] cvc);
      @(negedge clk);
      in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0; flow_ctrl_in = {cv, cvc};
   endtask

   task automatic check_state(input string name, input logic eb, ee, input logic [15:0] ec);
      check({name, "_busy"}, 64'(busy), 64'(eb));
      check({name, "_error"}, 64'(error), 64'(ee));
      check({name, "_credits"}, 64'(vc_credits), 64'(ec));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0; flow_ctrl_in = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [1:0] t6_vc;

   initial begin
      // Table: packet H,B,T on VC0; reset; four single-flit packets; credit corner cases.
      rows[0]  = mk(0, 1, 1, 0, 0, 2'd0, 1, 1, 2'd0, 1, 1, 0, 16'h7888);
      rows[1]  = mk(0, 1, 0, 0, 0, 2'd0, 1, 1, 2'd0, 0, 1, 0, 16'h6888);
      rows[2]  = mk(0, 1, 0, 1, 0, 2'd0, 1, 1, 2'd0, 0, 0, 0, 16'h5888);
      rows[3]  = mk(1, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0, 16'h8888);
      rows[4]  = mk(0, 1, 1, 1, 0, 2'd0, 1, 1, 2'd0, 1, 0, 0, 16'h7888);
      rows[5]  = mk(0, 1, 1, 1, 0, 2'd0, 1, 1, 2'd1, 1, 0, 0, 16'h7788);
      rows[6]  = mk(0, 1, 1, 1, 0, 2'd0, 1, 1, 2'd2, 1, 0, 0, 16'h7778);
      rows[7]  = mk(0, 1, 1, 1, 0, 2'd0, 1, 1, 2'd3, 1, 0, 0, 16'h7777);
`ifdef RTR_INJ_ATOMIC_VC_EN
      rows[8]  = mk(0, 1, 1, 1, 1, 2'd0, 0, 0, 2'd0, 1, 0, 0, 16'h8777);
      rows[9]  = mk(0, 0, 0, 0, 1, 2'd1, 1, 0, 2'd0, 0, 0, 0, 16'h8877);
      rows[10] = mk(0, 1, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0, 1, 16'h8877);
`else
      rows[8]  = mk(0, 1, 1, 1, 1, 2'd0, 1, 1, 2'd0, 1, 0, 0, 16'h7777);
      rows[9]  = mk(0, 0, 0, 0, 1, 2'd1, 1, 0, 2'd0, 0, 0, 0, 16'h7877);
      rows[10] = mk(0, 1, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0, 1, 16'h7877);
`endif
      rows[11] = mk(1, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0, 16'h8888);
      rows[12] = mk(0, 0, 0, 0, 1, 2'd3, 1, 0, 2'd0, 0, 0, 1, 16'h8888);
      rows[13] = mk(1, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0, 16'h8888);

      reset = 1'b1; in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0;
      in_data = '0; flow_ctrl_in = '0;
      repeat (3) @(negedge clk);
      check("reset_ready", 64'(in_ready), 64'(0));
      check("reset_chan", 64'(channel_out[68]), 64'(0));
      check_state("reset", 0, 0, 16'h8888);
      reset = 1'b0;

      for (int i = 0; i < NRows; i++) begin
         @(negedge clk);
         if (i > 0) check_state($sformatf("row%0d", i - 1), rows[i-1].ebusy, rows[i-1].eerr,
                                rows[i-1].ecred);
         reset = rows[i].rst; in_valid = rows[i].v; in_head = rows[i].h; in_tail = rows[i].t;
         in_data = 64'hA5A5_0000_0000_0000 | 64'(i);
         flow_ctrl_in = {rows[i].cv, rows[i].cvc};
         #1;
         check($sformatf("row%0d_ready", i), 64'(in_ready), 64'(rows[i].ready));
         if (rows[i].emit) exp_q.push_back({rows[i].evc, rows[i].ehead, rows[i].t, in_data});
      end
      @(negedge clk);
      check_state("row13", rows[NRows-1].ebusy, rows[NRows-1].eerr, rows[NRows-1].ecred);
      reset = 1'b0;

      // 10-flit packet on VC0 with no credits: 8 go, then stall until one credit returns.
      for (int k = 0; k < 8; k++)
         step(1, k == 0, 0, 64'hB000 + 64'(k), 0, 2'd0, 1, 2'd0, k == 0, "t3_flit");
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 0, 64'hB008, 0, 2'd0, 0, 2'd0, 0, "t3_stall");
         check("t3_stall_busy", 64'(busy), 64'(1));
      end
      step(1, 0, 0, 64'hB008, 1, 2'd0, 0, 2'd0, 0, "t3_credit_cycle");
      step(1, 0, 0, 64'hB008, 0, 2'd0, 1, 2'd0, 0, "t3_one_more");
      step(1, 0, 1, 64'hB009, 0, 2'd0, 0, 2'd0, 0, "t3_after_one");
      step(1, 0, 1, 64'hB009, 1, 2'd0, 0, 2'd0, 0, "t3_credit2");
      step(1, 0, 1, 64'hB009, 0, 2'd0, 1, 2'd0, 0, "t3_tail");
      idle(0, 2'd0);
      @(negedge clk);
      check_state("t3_end", 0, 0, 16'h0888);

      // Same-cycle send and credit return on VC2 at 3 credits.
      do_reset();
      step(1, 1, 1, 64'hC000, 0, 2'd0, 1, 2'd0, 1, "t4_vc0");
      step(1, 1, 1, 64'hC001, 0, 2'd0, 1, 2'd1, 1, "t4_vc1");
      step(1, 1, 0, 64'hC002, 0, 2'd0, 1, 2'd2, 1, "t4_head");
      for (int k = 0; k < 4; k++)
         step(1, 0, 0, 64'hC010 + 64'(k), 0, 2'd0, 1, 2'd2, 0, "t4_body");
      step(1, 0, 0, 64'hC020, 1, 2'd2, 1, 2'd2, 0, "t4_same");
      idle(0, 2'd0);
      @(negedge clk);
      check_state("t4_same", 1, 0, 16'h7738);
      step(1, 0, 1, 64'hC030, 0, 2'd0, 1, 2'd2, 0, "t4_tail");
      idle(0, 2'd0);
      @(negedge clk);
      check_state("t4_end", 0, 0, 16'h7728);

      // Stray head mid-packet on VC3 is sent as body and flags an error.
      step(1, 1, 0, 64'hD000, 0, 2'd0, 1, 2'd3, 1, "t5_head");
      step(1, 1, 0, 64'hD001, 0, 2'd0, 1, 2'd3, 0, "t5_stray");
      step(1, 0, 1, 64'hD002, 0, 2'd0, 1, 2'd3, 0, "t5_tail");
      idle(0, 2'd0);
      @(negedge clk);
      check_state("t5_end", 0, 1, 16'h7725);

      // Reset in the middle of a packet abandons it and restores credits.
      do_reset();
      step(1, 1, 0, 64'hE000, 0, 2'd0, 1, 2'd0, 1, "mid_head");
      do_reset();
      @(negedge clk);
      check_state("mid_reset", 0, 0, 16'h8888);

      // VC0 one credit short, others full, pointer back at 0.
      for (int k = 0; k < 4; k++)
         step(1, 1, 1, 64'hF000 + 64'(k), 0, 2'd0, 1, 2'(k), 1, "t6_fill");
      idle(1, 2'd1);
      idle(1, 2'd2);
      idle(1, 2'd3);
      idle(0, 2'd0);
      @(negedge clk);
      check_state("t6_setup", 0, 0, 16'h7888);
`ifdef RTR_INJ_ATOMIC_VC_EN
      t6_vc = 2'd1;
`else
      t6_vc = 2'd0;
`endif
      step(1, 1, 1, 64'hF100, 0, 2'd0, 1, t6_vc, 1, "t6_pick");
      idle(0, 2'd0);
      @(negedge clk);
`ifdef RTR_INJ_ATOMIC_VC_EN
      check_state("t6_end", 0, 0, 16'h7788);
`else
      check_state("t6_end", 0, 0, 16'h6888);
`endif

      repeat (2) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
